// File: rtl/nn_pkg.sv
//------------------------------------------------------------------------------
// nn_pkg : widths and FSM state type shared by the neural-network blocks
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package nn_pkg;

  localparam int H_W    = 10;  // hidden activation, unsigned Q3.7
  localparam int W_W    = 8;   // output weight, unsigned Q1.7
  localparam int FRAC_W = 7;
  localparam int OUT_W  = 13;  // result, Q6.7

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } nn_state_t;

endpackage

`default_nettype wire

// File: rtl/output_neuron_mac.sv
//------------------------------------------------------------------------------
// output_neuron_mac : serial MAC of hidden activations against output weights,
//                     producing the weighted sum and a threshold class bit
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module output_neuron_mac
  import nn_pkg::*;
#(
  parameter int N_HIDDEN = 4,
  parameter int IDX_W    = $clog2(N_HIDDEN)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [H_W-1:0]   h_i,
  input  logic             h_valid_i,
  output logic             h_ready_o,
  output logic [IDX_W-1:0] w_idx_o,
  input  logic [W_W-1:0]   w_i,
  input  logic [OUT_W-1:0] thresh_i,
  output logic [OUT_W-1:0] out_o,
  output logic             class_o,
  output logic             out_valid_o,
  output logic             busy_o
);

  localparam int PROD_W = H_W + W_W;
  localparam int ACC_W  = (N_HIDDEN > 4) ? PROD_W + $clog2(N_HIDDEN) : 20;
  localparam int SHR_W  = ACC_W - FRAC_W;

  nn_state_t          state, state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [IDX_W-1:0]   idx;
  logic [PROD_W-1:0]  prod;
  logic [ACC_W-1:0]   acc_sum;
  logic [SHR_W-1:0]   acc_shr;
  logic [OUT_W-1:0]   result;
  logic               xfer;
  logic               last;

  assign prod    = PROD_W'(h_i) * PROD_W'(w_i);
  assign acc_sum = acc + ACC_W'(prod);
  assign acc_shr = acc_sum[ACC_W-1:FRAC_W];
  assign xfer    = (state == ST_ACCUM) && h_valid_i;
  assign last    = (idx == IDX_W'(N_HIDDEN - 1));

  // Only wider accumulators can exceed the 13-bit result range.
  generate
    if (SHR_W > OUT_W) begin : g_sat
      assign result = (|acc_shr[SHR_W-1:OUT_W]) ? {OUT_W{1'b1}} : acc_shr[OUT_W-1:0];
    end else begin : g_nosat
      assign result = acc_shr[OUT_W-1:0];
    end
  endgenerate

  always_comb begin
    state_nxt   = state;
    h_ready_o   = 1'b0;
    out_valid_o = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        h_ready_o = 1'b1;
        if (h_valid_i && last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= ST_IDLE;
      acc     <= '0;
      idx     <= '0;
      out_o   <= '0;
      class_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && start_i) begin
        acc <= '0;
        idx <= '0;
      end
      if (xfer) begin
        acc <= acc_sum;
        // Wrap to 0 on the last transfer so the index reads 0 again in IDLE.
        idx <= last ? '0 : idx + IDX_W'(1);
        if (last) begin
          out_o   <= result;
          class_o <= (result >= thresh_i);
        end
      end
    end
  end

  assign w_idx_o = idx;
  assign busy_o  = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_output_neuron_mac.sv
//------------------------------------------------------------------------------
// tb_output_neuron_mac : scoreboard bench for output_neuron_mac
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_output_neuron_mac;
  import nn_pkg::*;

  localparam int N = 4;
  localparam int IW = $clog2(N);

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            start_i;
  logic [H_W-1:0]  h_i;
  logic            h_valid_i;
  logic            h_ready_o;
  logic [IW-1:0]   w_idx_o;
  logic [W_W-1:0]  w_i;
  logic [OUT_W-1:0] thresh_i;
  logic [OUT_W-1:0] out_o;
  logic            class_o;
  logic            out_valid_o;
  logic            busy_o;

  logic [W_W-1:0]  wmem [N];
  logic [H_W-1:0]  hv   [N];
  int              gap  [N];

  logic [OUT_W:0]  sb_q[$];
  int              total = 0;
  int              passed = 0;
  int              pulses = 0;
  logic            prev_valid = 1'b0;

  output_neuron_mac #(.N_HIDDEN(N), .IDX_W(IW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .h_i         (h_i),
    .h_valid_i   (h_valid_i),
    .h_ready_o   (h_ready_o),
    .w_idx_o     (w_idx_o),
    .w_i         (w_i),
    .thresh_i    (thresh_i),
    .out_o       (out_o),
    .class_o     (class_o),
    .out_valid_o (out_valid_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;
  assign w_i = wmem[w_idx_o];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Result monitor: pops the scoreboard on every out_valid_o pulse.
  always @(negedge clk_i) begin
    logic [OUT_W:0] e;
    if (rst_i === 1'b1 && out_valid_o === 1'b1) begin
      pulses++;
      if (prev_valid) check("pulse_width", 32'd2, 32'd1);
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_out", 32'(out_o), 32'(e[OUT_W:1]));
        check("sb_class", 32'(class_o), 32'(e[0]));
      end
    end
    prev_valid = (out_valid_o === 1'b1);
  end

  task automatic run(input logic [OUT_W-1:0] th, input bit disturb);
    logic [19:0]      acc;
    logic [OUT_W-1:0] eo;
    int               edges;
    int               gsum;
    acc  = '0;
    gsum = 0;
    for (int i = 0; i < N; i++) begin
      acc  = acc + 20'(hv[i]) * 20'(wmem[i]);
      gsum = gsum + gap[i];
    end
    eo = acc[19:7];
    sb_q.push_back({eo, eo >= th});
    thresh_i = th;
    start_i  = 1'b1;
    edges    = 0;
    @(posedge clk_i); #1; edges++;
    start_i = disturb;
    check("ready_after_start", 32'(h_ready_o), 32'd1);
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        check("gap_idx", 32'(w_idx_o), 32'(i));
        @(posedge clk_i); #1; edges++;
      end
      check("xfer_idx", 32'(w_idx_o), 32'(i));
      h_i = hv[i];
      h_valid_i = 1'b1;
      @(posedge clk_i); #1; edges++;
      h_valid_i = 1'b0;
    end
    check("pulse_now", 32'(out_valid_o), 32'd1);
    check("latency", 32'(edges), 32'(1 + N + gsum));
    check("busy_done", 32'(busy_o), 32'd1);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("busy_after", 32'(busy_o), 32'd0);
    check("valid_after", 32'(out_valid_o), 32'd0);
    check("out_hold", 32'(out_o), 32'(eo));
    check("idx_idle", 32'(w_idx_o), 32'd0);
  endtask

  task automatic set_all(input logic [H_W-1:0] h, input logic [W_W-1:0] w);
    for (int i = 0; i < N; i++) begin
      hv[i] = h; wmem[i] = w; gap[i] = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    rst_i = 1'b0; start_i = 1'b0; h_i = '0; h_valid_i = 1'b0; thresh_i = '0;
    set_all('0, '0);
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", 32'(h_ready_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_idx", 32'(w_idx_o), 32'd0);
    check("rst_out", 32'(out_o), 32'd0);
    check("rst_class", 32'(class_o), 32'd0);
    check("rst_valid", 32'(out_valid_o), 32'd0);
    rst_i = 1'b1;

    // Idle with valid asserted but no start.
    h_valid_i = 1'b1;
    h_i = 10'h3FF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      check("idle_ready", 32'(h_ready_o), 32'd0);
      check("idle_busy", 32'(busy_o), 32'd0);
    end
    h_valid_i = 1'b0;
    check("idle_out", 32'(out_o), 32'd0);
    check("idle_pulses", 32'(pulses), 32'd0);

    set_all(10'h080, 8'h80);
    run(13'h200, 1'b0);
    run(13'h201, 1'b0);

    set_all(10'h3FF, 8'hFF);
    run(13'h1FD8, 1'b0);

    set_all(10'h080, 8'h00);
    wmem[0] = 8'h40; wmem[1] = 8'h80; wmem[2] = 8'h00; wmem[3] = 8'hFF;
    gap[0] = 0; gap[1] = 3; gap[2] = 1; gap[3] = 0;
    run(13'h1C0, 1'b0);

    // Start held high through ACCUM and DONE must not restart anything.
    run(13'h1BF, 1'b1);

    // Mixed per-index data.
    hv[0] = 10'h1A5; hv[1] = 10'h07F; hv[2] = 10'h300; hv[3] = 10'h001;
    wmem[0] = 8'h11; wmem[1] = 8'hC3; wmem[2] = 8'h7E; wmem[3] = 8'hFF;
    gap[0] = 2; gap[1] = 0; gap[2] = 0; gap[3] = 1;
    run(13'h0FF, 1'b0);

    // Abort with reset after the second transfer.
    set_all(10'h0FF, 8'hF0);
    p0 = pulses;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      h_i = hv[i]; h_valid_i = 1'b1;
      @(posedge clk_i); #1;
    end
    h_valid_i = 1'b0;
    check("pre_abort_idx", 32'(w_idx_o), 32'd2);
    #2 rst_i = 1'b0;
    #1;
    check("abort_ready", 32'(h_ready_o), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_idx", 32'(w_idx_o), 32'd0);
    check("abort_out", 32'(out_o), 32'd0);
    check("abort_class", 32'(class_o), 32'd0);
    check("abort_valid", 32'(out_valid_o), 32'd0);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    check("abort_no_pulse", 32'(pulses), 32'(p0));

    // Recovery after abort.
    set_all(10'h080, 8'h80);
    run(13'h100, 1'b0);

    repeat (2) @(posedge clk_i);
    #1;
    check("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
